// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, branch-squash, memory-wait and HALT sequencing.
// Optional perf counters: define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             MemRead2_3,
   input  logic [2:0]       wreg2_3,
   input  logic [5:0]       rsrd1_2,
   input  logic             use_rs1_2,
   input  logic             use_rd1_2,
   input  logic             br_taken,
   input  logic             halt2_3,
   input  logic             restart,
   input  logic             mem_busy,
   output logic             pipe_en,
   output logic             pc_write,
   output logic             ir_write,
   output logic             bubble2_3,
   output logic             flush1_2,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } state_t;

   localparam logic [2:0] FC = FLUSH_CYCLES[2:0];

   state_t     state_q, state_d;
   logic [2:0] fcnt_q, fcnt_d;
   logic       lu;

   assign lu = MemRead2_3 &&
      ((use_rs1_2 && (rsrd1_2[5:3] == wreg2_3)) ||
       (use_rd1_2 && (rsrd1_2[2:0] == wreg2_3)));

   // State and flush-count registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         fcnt_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // Next state and same-cycle pipeline controls
   always_comb begin
      state_d   = state_q;
      fcnt_d    = fcnt_q;
      pipe_en   = 1'b1;
      pc_write  = 1'b1;
      ir_write  = 1'b1;
      bubble2_3 = 1'b0;
      flush1_2  = 1'b0;
      halted    = 1'b0;
      if (!rst_n) begin
         pipe_en  = 1'b0;
         pc_write = 1'b0;
         ir_write = 1'b0;
      end else if (mem_busy) begin
         pipe_en  = 1'b0;
         pc_write = 1'b0;
         ir_write = 1'b0;
         halted   = (state_q == HALT);
      end else begin
         unique case (state_q)
            RUN: begin
               if (halt2_3) begin
                  pc_write = 1'b0;
                  ir_write = 1'b0;
                  flush1_2 = 1'b1;
                  state_d  = HALT;
               end else if (br_taken) begin
                  flush1_2  = 1'b1;
                  bubble2_3 = 1'b1;
                  if (FC != 3'd0) begin
                     state_d = FLUSH;
                     fcnt_d  = FC;
                  end
               end else if (lu) begin
                  pc_write  = 1'b0;
                  ir_write  = 1'b0;
                  bubble2_3 = 1'b1;
               end
            end
            FLUSH: begin
               flush1_2 = 1'b1;
               if (halt2_3) begin
                  pc_write = 1'b0;
                  ir_write = 1'b0;
                  state_d  = HALT;
                  fcnt_d   = 3'd0;
               end else begin
                  fcnt_d = fcnt_q - 3'd1;
                  if (fcnt_q <= 3'd1) begin
                     state_d = RUN;
                     fcnt_d  = 3'd0;
                  end
               end
            end
            HALT: begin
               halted    = 1'b1;
               pc_write  = 1'b0;
               ir_write  = 1'b0;
               bubble2_3 = 1'b1;
               if (restart) state_d = RUN;
            end
            default: begin
               state_d = RUN;
               fcnt_d  = 3'd0;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q, flush_q;
   logic             stall_ev;

   assign stall_ev = rst_n && !mem_busy && (state_q == RUN) &&
                     !halt2_3 && !br_taken && lu;

   // Saturating stall and flush event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall_ev && (stall_q != '1)) stall_q <= stall_q + 1'b1;
         if (flush1_2 && (flush_q != '1)) flush_q <= flush_q + 1'b1;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl outputs.
// Output vector order: pipe_en,pc_write,ir_write,bubble,flush,halted.
module tb_hazard_ctrl;

   localparam logic [5:0] DEF  = 6'b111000;
   localparam logic [5:0] LU   = 6'b100100;
   localparam logic [5:0] BR   = 6'b111110;
   localparam logic [5:0] FL   = 6'b111010;
   localparam logic [5:0] HIN  = 6'b100010;
   localparam logic [5:0] HLT  = 6'b100101;
   localparam logic [5:0] BSY  = 6'b000000;
   localparam logic [5:0] BSYH = 6'b000001;
   localparam logic [5:0] ZERO = 6'b000000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemRead2_3, use_rs1_2, use_rd1_2;
   logic [2:0]  wreg2_3;
   logic [5:0]  rsrd1_2;
   logic        br_taken, halt2_3, restart, mem_busy;
   logic        pipe_en, pc_write, ir_write;
   logic        bubble2_3, flush1_2, halted;
   logic [15:0] stall_cnt, flush_cnt;

   int vec  = 0;
   int errs = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .MemRead2_3(MemRead2_3), .wreg2_3(wreg2_3),
      .rsrd1_2(rsrd1_2), .use_rs1_2(use_rs1_2),
      .use_rd1_2(use_rd1_2), .br_taken(br_taken),
      .halt2_3(halt2_3), .restart(restart),
      .mem_busy(mem_busy), .pipe_en(pipe_en),
      .pc_write(pc_write), .ir_write(ir_write),
      .bubble2_3(bubble2_3), .flush1_2(flush1_2),
      .halted(halted), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
   );

   function automatic logic [5:0] outs();
      return {pipe_en, pc_write, ir_write,
              bubble2_3, flush1_2, halted};
   endfunction

   task automatic clr();
      MemRead2_3 = 0; wreg2_3 = 0; rsrd1_2 = 0;
      use_rs1_2 = 0; use_rd1_2 = 0; br_taken = 0;
      halt2_3 = 0; restart = 0; mem_busy = 0;
   endtask

   // advance to 2ns after the next rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst_n = 0;
      clr();
      #3;
      vec++;
      if (outs() !== ZERO) begin
         errs++;
         $display("FAIL reset_outs got %b want %b", outs(), ZERO);
      end
      vec++;
      if ({stall_cnt, flush_cnt} !== 32'd0) begin
         errs++;
         $display("FAIL reset_cnt got %h want 0", {stall_cnt, flush_cnt});
      end
      tick();
      rst_n = 1;
      #1;
      vec++;
      if (outs() !== DEF) begin
         errs++;
         $display("FAIL reset_release got %b want %b", outs(), DEF);
      end
   endtask

   task automatic test_load_use();
      tick();
      MemRead2_3 = 1; wreg2_3 = 3; rsrd1_2 = 6'b011_001; use_rs1_2 = 1;
      #1;
      vec++;
      if (outs() !== LU) begin
         errs++;
         $display("FAIL lu_rs got %b want %b", outs(), LU);
      end
      tick();
      MemRead2_3 = 0;
      #1;
      vec++;
      if (outs() !== DEF) begin
         errs++;
         $display("FAIL lu_after got %b want %b", outs(), DEF);
      end
      tick();
      clr();
      MemRead2_3 = 1; wreg2_3 = 3; rsrd1_2 = 6'b000_011; use_rd1_2 = 1;
      #1;
      vec++;
      if (outs() !== LU) begin
         errs++;
         $display("FAIL lu_rd got %b want %b", outs(), LU);
      end
      tick();
      wreg2_3 = 5; use_rs1_2 = 1;
      #1;
      vec++;
      if (outs() !== DEF) begin
         errs++;
         $display("FAIL lu_nomatch got %b want %b", outs(), DEF);
      end
      tick();
      clr();
   endtask

   task automatic test_no_use();
      tick();
      MemRead2_3 = 1; wreg2_3 = 3; rsrd1_2 = 6'b011_011;
      #1;
      vec++;
      if (outs() !== DEF) begin
         errs++;
         $display("FAIL no_use got %b want %b", outs(), DEF);
      end
      tick();
      clr();
   endtask

   task automatic test_branch();
      tick();
      br_taken = 1;
      #1;
      vec++;
      if (outs() !== BR) begin
         errs++;
         $display("FAIL br_c0 got %b want %b", outs(), BR);
      end
      tick();
      br_taken = 0;
      #1;
      vec++;
      if (outs() !== FL) begin
         errs++;
         $display("FAIL br_c1 got %b want %b", outs(), FL);
      end
      tick();
      #1;
      vec++;
      if (outs() !== DEF) begin
         errs++;
         $display("FAIL br_c2 got %b want %b", outs(), DEF);
      end
   endtask

   task automatic test_br_lu();
      tick();
      br_taken = 1;
      MemRead2_3 = 1; wreg2_3 = 3; rsrd1_2 = 6'b011_001; use_rs1_2 = 1;
      #1;
      vec++;
      if (outs() !== BR) begin
         errs++;
         $display("FAIL brlu_c0 got %b want %b", outs(), BR);
      end
      tick();
      br_taken = 1;
      #1;
      vec++;
      if (outs() !== FL) begin
         errs++;
         $display("FAIL brlu_flush got %b want %b", outs(), FL);
      end
      tick();
      clr();
      #1;
      vec++;
      if (outs() !== DEF) begin
         errs++;
         $display("FAIL brlu_end got %b want %b", outs(), DEF);
      end
   endtask

   task automatic test_halt();
      tick();
      halt2_3 = 1;
      #1;
      vec++;
      if (outs() !== HIN) begin
         errs++;
         $display("FAIL halt_c0 got %b want %b", outs(), HIN);
      end
      tick();
      halt2_3 = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         vec++;
         if (outs() !== HLT) begin
            errs++;
            $display("FAIL halt_hold%0d got %b want %b", i, outs(), HLT);
         end
         tick();
      end
      restart = 1; mem_busy = 1;
      #1;
      vec++;
      if (outs() !== BSYH) begin
         errs++;
         $display("FAIL halt_busy got %b want %b", outs(), BSYH);
      end
      tick();
      restart = 0; mem_busy = 0;
      #1;
      vec++;
      if (outs() !== HLT) begin
         errs++;
         $display("FAIL halt_busyhold got %b want %b", outs(), HLT);
      end
      tick();
      restart = 1;
      #1;
      vec++;
      if (outs() !== HLT) begin
         errs++;
         $display("FAIL halt_rst_cyc got %b want %b", outs(), HLT);
      end
      tick();
      restart = 0;
      #1;
      vec++;
      if (outs() !== DEF) begin
         errs++;
         $display("FAIL halt_exit got %b want %b", outs(), DEF);
      end
   endtask

   task automatic test_busy_flush();
      tick();
      br_taken = 1;
      tick();
      br_taken = 0; mem_busy = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         vec++;
         if (outs() !== BSY) begin
            errs++;
            $display("FAIL busy_fl%0d got %b want %b", i, outs(), BSY);
         end
         tick();
      end
      mem_busy = 0;
      #1;
      vec++;
      if (outs() !== FL) begin
         errs++;
         $display("FAIL busy_fl_done got %b want %b", outs(), FL);
      end
      tick();
      #1;
      vec++;
      if (outs() !== DEF) begin
         errs++;
         $display("FAIL busy_fl_run got %b want %b", outs(), DEF);
      end
      tick();
      mem_busy = 1; br_taken = 1; halt2_3 = 1;
      #1;
      vec++;
      if (outs() !== BSY) begin
         errs++;
         $display("FAIL busy_run got %b want %b", outs(), BSY);
      end
      tick();
      clr();
      #1;
      vec++;
      if (outs() !== DEF) begin
         errs++;
         $display("FAIL busy_ignored got %b want %b", outs(), DEF);
      end
   endtask

   task automatic test_halt_in_flush();
      tick();
      br_taken = 1;
      tick();
      br_taken = 0; halt2_3 = 1;
      #1;
      vec++;
      if (outs() !== HIN) begin
         errs++;
         $display("FAIL fl_halt got %b want %b", outs(), HIN);
      end
      tick();
      halt2_3 = 0;
      #1;
      vec++;
      if (outs() !== HLT) begin
         errs++;
         $display("FAIL fl_halted got %b want %b", outs(), HLT);
      end
      restart = 1;
      tick();
      restart = 0;
      #1;
      vec++;
      if (outs() !== DEF) begin
         errs++;
         $display("FAIL fl_halt_exit got %b want %b", outs(), DEF);
      end
   endtask

   task automatic test_async_reset();
      tick();
      halt2_3 = 1;
      tick();
      halt2_3 = 0;
      #1;
      rst_n = 0;
      #1;
      vec++;
      if (outs() !== ZERO) begin
         errs++;
         $display("FAIL areset_outs got %b want %b", outs(), ZERO);
      end
      tick();
      rst_n = 1;
      #1;
      vec++;
      if (outs() !== DEF) begin
         errs++;
         $display("FAIL areset_run got %b want %b", outs(), DEF);
      end
      tick();
      #1;
      vec++;
      if (outs() !== DEF) begin
         errs++;
         $display("FAIL areset_run2 got %b want %b", outs(), DEF);
      end
   endtask

   task automatic test_perf();
      logic [15:0] es, ef;
`ifdef HAZARD_PERF_CNT_EN
      es = 16'd2; ef = 16'd2;
`else
      es = 16'd0; ef = 16'd0;
`endif
      tick();
      rst_n = 0;
      #1;
      rst_n = 1;
      for (int k = 0; k < 2; k++) begin
         tick();
         MemRead2_3 = 1; wreg2_3 = 3;
         rsrd1_2 = 6'b011_001; use_rs1_2 = 1;
         tick();
         clr();
      end
      tick();
      br_taken = 1;
      tick();
      br_taken = 0;
      tick();
      tick();
      vec++;
      if (stall_cnt !== es) begin
         errs++;
         $display("FAIL perf_stall got %0d want %0d", stall_cnt, es);
      end
      vec++;
      if (flush_cnt !== ef) begin
         errs++;
         $display("FAIL perf_flush got %0d want %0d", flush_cnt, ef);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_use();
      test_branch();
      test_br_lu();
      test_halt();
      test_busy_flush();
      test_halt_in_flush();
      test_async_reset();
      test_perf();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
